// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- sequencer for the single shared memory port of the
// multicycle MIPS core.
//
// Four requesters compete for the port: instruction fetch (PC), load/store
// (ALUOut), register-indirect access (RD) and exception-vector reads
// (words 255/254/253). A grant is held for MEM_LATENCY wait-state cycles
// (ACCESS), then the winner gets a one-cycle ack (DONE).
//
// Optional feature macro: FETCH_STARVE_GUARD_EN
//   When defined, a saturating counter tracks data/rd grants made while fetch
//   is waiting. At STARVE_LIMIT, fetch outranks data and rd for the next grant.
//   When undefined, priority is strictly exc > data > rd > fetch.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_fetch               fetch request (select 3'b000, read only)
//   req_data, data_wr       load/store request (3'b001); data_wr=1 -> store
//   req_rd, rd_wr           register-indirect request (3'b101); rd_wr=1 -> write
//   req_exc, exc_sel[1:0]   exception-vector read; 0/1/2 -> 3'b010/011/100,
//                           3 is illegal and falls back to 3'b010
//   mux_mem_end[2:0]        memory-address mux select
//   mem_wr                  write strobe, first ACCESS cycle of a write only
//   busy                    high in ACCESS and DONE
//   ack_fetch/data/rd/exc   one-cycle completion pulse to the winner
//   exc_bad                 pulses with ack_exc when exc_sel was 3
module mem_port_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_fetch,
   input  logic       req_data,
   input  logic       data_wr,
   input  logic       req_rd,
   input  logic       rd_wr,
   input  logic       req_exc,
   input  logic [1:0] exc_sel,
   output logic [2:0] mux_mem_end,
   output logic       mem_wr,
   output logic       busy,
   output logic       ack_fetch,
   output logic       ack_data,
   output logic       ack_rd,
   output logic       ack_exc,
   output logic       exc_bad
);

   localparam int            WW        = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // Latched grant: one-hot winner {exc, rd, data, fetch}, select code,
   // write flag and illegal-vector flag.
   typedef struct packed {
      logic [3:0] win;
      logic [2:0] sel;
      logic       wr;
      logic       bad;
   } grant_t;

   state_t        state_q, state_d;
   grant_t        gq, gd;
   logic [WW-1:0] wait_q;
   logic [3:0]    req, cand, gnt, mask_q;
   logic          starve;
   logic [2:0]    exc_code;

   assign req = {req_exc, req_rd, req_data, req_fetch};

   // In the IDLE cycle after DONE the just-acked requester still occupies its
   // priority slot even though its request is ignored: a stale or held request
   // must not hand the port to a lower-priority requester, only to a higher one.
   assign cand = req | mask_q;

   always_comb begin
      gnt = '0;
      if (cand[3])                gnt[3] = 1'b1;
      else if (starve && cand[0]) gnt[0] = 1'b1;
      else if (cand[1])           gnt[1] = 1'b1;
      else if (cand[2])           gnt[2] = 1'b1;
      else if (cand[0])           gnt[0] = 1'b1;
      gnt = gnt & ~mask_q;
   end

   always_comb begin
      case (exc_sel)
         2'd1:    exc_code = 3'b011;
         2'd2:    exc_code = 3'b100;
         default: exc_code = 3'b010;   // 0, and illegal 3 falls back to vector 255
      endcase
   end

`ifdef FETCH_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_q;

   assign starve = (starve_q >= CW'(STARVE_LIMIT));

   // Only IDLE cycles matter: that is where grants happen and where an
   // absent fetch request resets the count.
   always_ff @(posedge clock) begin
      if (reset)
         starve_q <= '0;
      else if (state_q == IDLE) begin
         if (!req_fetch || gnt[0])
            starve_q <= '0;
         else if ((gnt[1] || gnt[2]) && !starve)
            starve_q <= starve_q + CW'(1);
      end
   end
`else
   // Limit has no effect without the guard.
   assign starve = 1'b0 & (STARVE_LIMIT > 0);
`endif

   always_comb begin
      state_d = state_q;
      gd      = gq;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               state_d = ACCESS;
               gd.win  = gnt;
               gd.sel  = 3'b000;
               gd.wr   = 1'b0;
               gd.bad  = 1'b0;
               if (gnt[3]) begin
                  gd.sel = exc_code;
                  gd.bad = (exc_sel == 2'd3);
               end else if (gnt[1]) begin
                  gd.sel = 3'b001;
                  gd.wr  = data_wr;
               end else if (gnt[2]) begin
                  gd.sel = 3'b101;
                  gd.wr  = rd_wr;
               end
            end
         end
         ACCESS:  if (wait_q == WAIT_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         gq      <= '0;
         wait_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         gq      <= gd;
         wait_q  <= (state_q == ACCESS) ? wait_q + WW'(1) : '0;
         mask_q  <= (state_q == DONE) ? gq.win : 4'b0000;
      end
   end

   // Outputs decode from registered state only; select is forced to 000 in IDLE.
   assign busy        = (state_q != IDLE);
   assign mux_mem_end = busy ? gq.sel : 3'b000;
   assign mem_wr      = (state_q == ACCESS) && (wait_q == '0) && gq.wr;
   assign {ack_exc, ack_rd, ack_data, ack_fetch} = (state_q == DONE) ? gq.win : 4'b0000;
   assign exc_bad     = (state_q == DONE) && gq.bad;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. The stimulus pushes the expected
// completion (requester, select code, write strobe, illegal flag) for each
// access. The monitor pops one entry per ack and checks the select held over
// the whole busy window, the write-strobe count and the busy length.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_fetch = 0, req_data = 0, data_wr = 0, req_rd = 0, rd_wr = 0, req_exc = 0;
   logic [1:0] exc_sel = 2'd0;
   logic [2:0] mux_mem_end;
   logic       mem_wr, busy, ack_fetch, ack_data, ack_rd, ack_exc, exc_bad;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
      .clock(clk), .reset(reset),
      .req_fetch(req_fetch), .req_data(req_data), .data_wr(data_wr),
      .req_rd(req_rd), .rd_wr(rd_wr), .req_exc(req_exc), .exc_sel(exc_sel),
      .mux_mem_end(mux_mem_end), .mem_wr(mem_wr), .busy(busy),
      .ack_fetch(ack_fetch), .ack_data(ack_data), .ack_rd(ack_rd), .ack_exc(ack_exc),
      .exc_bad(exc_bad)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;    // 0 fetch, 1 data, 2 rd, 3 exc
      logic [2:0] sel;
      logic       wr;
      logic       bad;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0, miscompares = 0, ack_cnt = 0;
   int   busy_len = 0, wr_cnt = 0;
   logic [2:0] sel0 = 3'b000;
   logic       sel_moved = 1'b0;
   wire  [3:0] acks = {ack_exc, ack_rd, ack_data, ack_fetch};

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t        e;
      logic [11:0] act, req;
      logic [1:0]  id;
      if (reset) begin
         busy_len  = 0;
         wr_cnt    = 0;
         sel_moved = 1'b0;
      end else begin
         if (busy) begin
            busy_len++;
            if (busy_len == 1) sel0 = mux_mem_end;
            else if (mux_mem_end != sel0) sel_moved = 1'b1;
         end else begin
            if (mux_mem_end != 3'b000 || mem_wr) begin
               miscompares++;
               $display("FAIL idle_outputs: sel=%b mem_wr=%b, need sel=000 mem_wr=0", mux_mem_end, mem_wr);
            end
         end
         if (mem_wr) wr_cnt++;
         if (exc_bad && !ack_exc) begin
            miscompares++;
            $display("FAIL exc_bad_alone: exc_bad high without ack_exc");
         end
         if (acks != 4'b0000) begin
            if (!$onehot(acks)) begin
               miscompares++;
               $display("FAIL ack_onehot: acks=%b", acks);
            end else if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_ack: acks=%b with empty scoreboard", acks);
            end else begin
               e   = exp_q.pop_front();
               id  = acks[3] ? 2'd3 : acks[2] ? 2'd2 : acks[1] ? 2'd1 : 2'd0;
               act = {id, sel0, 2'(wr_cnt), exc_bad, 3'(busy_len), sel_moved};
               req = {e.id, e.sel, 1'b0, e.wr, e.bad, 3'(LAT + 1), 1'b0};
               vectors++;
               if (act !== req) begin
                  miscompares++;
                  $display("FAIL access_%0d: got id=%0d sel=%b wr_cnt=%0d bad=%b busy=%0d moved=%b, need id=%0d sel=%b wr_cnt=%0d bad=%b busy=%0d moved=0",
                           ack_cnt, id, sel0, wr_cnt, exc_bad, busy_len, sel_moved,
                           e.id, e.sel, e.wr, e.bad, LAT + 1);
               end
            end
            ack_cnt++;
            busy_len  = 0;
            wr_cnt    = 0;
            sel_moved = 1'b0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, need %0d", name, act, req);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic [2:0] sel, input logic wr, input logic bad);
      exp_t e;
      e.id = id; e.sel = sel; e.wr = wr; e.bad = bad;
      exp_q.push_back(e);
   endtask

   // Waits (at posedges, after the monitor has updated) until ack_cnt reaches
   // target, then steps 1 time unit past the edge so callers drop requests
   // in the cycle following the ack.
   task automatic wait_acks(input int target, input string name);
      int n = 0;
      while (ack_cnt < target && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_timeout"}, (ack_cnt >= target) ? 1 : 0, 1);
      #1;
   endtask

   task automatic chk_reset_outputs(input string name);
      @(negedge clk);
      chk({name, "_sel"},   int'(mux_mem_end), 0);
      chk({name, "_busy"},  int'(busy), 0);
      chk({name, "_wr"},    int'(mem_wr), 0);
      chk({name, "_acks"},  int'({acks, exc_bad}), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset_state");
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: lone fetch read
      base = ack_cnt;
      push(2'd0, 3'b000, 1'b0, 1'b0);
      req_fetch = 1'b1;
      wait_acks(base + 1, "fetch_only");
      req_fetch = 1'b0;

      // 2: store beats fetch; fetch follows
      base = ack_cnt;
      push(2'd1, 3'b001, 1'b1, 1'b0);
      push(2'd0, 3'b000, 1'b0, 1'b0);
      req_data = 1'b1; data_wr = 1'b1; req_fetch = 1'b1;
      wait_acks(base + 1, "data_first");
      req_data = 1'b0; data_wr = 1'b0;
      wait_acks(base + 2, "fetch_after_data");
      req_fetch = 1'b0;

      // 3: exception vectors, including the illegal selector
      for (int s = 0; s < 4; s++) begin
         logic [2:0] code;
         code = (s == 1) ? 3'b011 : (s == 2) ? 3'b100 : 3'b010;
         base = ack_cnt;
         push(2'd3, code, 1'b0, (s == 3));
         exc_sel = 2'(s);
         req_exc = 1'b1;
         wait_acks(base + 1, "exc_vector");
         req_exc = 1'b0;
      end

      // 4: reset in second ACCESS cycle of an rd write: no ack_rd
      @(posedge clk); #1;
      req_rd = 1'b1; rd_wr = 1'b1;
      @(posedge clk);                 // grant
      @(negedge clk);                 // first ACCESS cycle
      chk("rd_access_sel", int'(mux_mem_end), 3'b101);
      chk("rd_access_wr",  int'(mem_wr), 1);
      @(posedge clk); #1;             // second ACCESS cycle
      reset = 1'b1; req_rd = 1'b0; rd_wr = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("mid_access_reset");
      reset = 1'b0;
      base = ack_cnt;
      repeat (6) @(posedge clk);
      chk("no_ack_after_reset", ack_cnt - base, 0);
      #1;

      // 5/6: data and fetch both held high
      base = ack_cnt;
`ifdef FETCH_STARVE_GUARD_EN
      for (int i = 0; i < 4; i++) push(2'd1, 3'b001, 1'b0, 1'b0);
      push(2'd0, 3'b000, 1'b0, 1'b0);
      push(2'd1, 3'b001, 1'b0, 1'b0);
`else
      for (int i = 0; i < 6; i++) push(2'd1, 3'b001, 1'b0, 1'b0);
`endif
      req_data = 1'b1; req_fetch = 1'b1;
      wait_acks(base + 6, "held_requests");
      req_data = 1'b0; req_fetch = 1'b0;

      repeat (8) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
